// File: rtl/brush_painter.sv
// brush_painter: turns one clipped square brush command, or a full-canvas
// clear, into a stream of single-pixel writes, one per clock.
// Ports:
//   clk, reset (sync, active high)
//   start, clear, cx, cy, radius, color : command inputs, sampled in IDLE
//   busy, done                          : command status
//   brush, wx, wy, newColor             : pixel store write port
module brush_painter #(
    parameter int         CANVAS_BITS = 7,
    parameter logic [2:0] ERASE_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] cx,
    input  logic [7:0] cy,
    input  logic [2:0] radius,
    input  logic [2:0] color,
    output logic       busy,
    output logic       done,
    output logic       brush,
    output logic [7:0] wx,
    output logic [7:0] wy,
    output logic [2:0] newColor
);

    localparam int                CB   = CANVAS_BITS;
    localparam logic signed [9:0] NMAX = 10'sd2 ** CB - 10'sd1;

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR, DONE} state_t;

    state_t        state_q, state_d;
    logic [CB-1:0] x_q, x_d, y_q, y_d;
    logic [CB-1:0] xlo_q, xlo_d, xhi_q, xhi_d, yhi_q, yhi_d;
    logic [2:0]    col_q, col_d;
    logic          busy_q, busy_d, done_q, done_d, brush_q, brush_d;
    logic [7:0]    wx_q, wx_d, wy_q, wy_d;
    logic [2:0]    nc_q, nc_d;

    // Clipping of the requested footprint, evaluated on the accept edge.
    logic signed [9:0] cx_s, cy_s, r_s;
    logic signed [9:0] xlo_s, xhi_s, ylo_s, yhi_s;
    logic              empty;

    always_comb begin
        cx_s  = signed'({2'b00, cx});
        cy_s  = signed'({2'b00, cy});
        r_s   = signed'({7'd0, radius});
        xlo_s = cx_s - r_s;
        xhi_s = cx_s + r_s;
        ylo_s = cy_s - r_s;
        yhi_s = cy_s + r_s;
        if (xlo_s < 10'sd0) xlo_s = 10'sd0;
        if (ylo_s < 10'sd0) ylo_s = 10'sd0;
        if (xhi_s > NMAX)   xhi_s = NMAX;
        if (yhi_s > NMAX)   yhi_s = NMAX;
        empty = (xlo_s > xhi_s) || (ylo_s > yhi_s);
    end

    logic last;
    assign last = (x_q == xhi_q) && (y_q == yhi_q);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xlo_d   = xlo_q;
        xhi_d   = xhi_q;
        yhi_d   = yhi_q;
        col_d   = col_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        brush_d = 1'b0;
        wx_d    = wx_q;
        wy_d    = wy_q;
        nc_d    = nc_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (clear) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    xlo_d   = '0;
                    xhi_d   = '1;
                    yhi_d   = '1;
                    col_d   = ERASE_COLOR;
                end else if (start) begin
                    busy_d  = 1'b1;
                    state_d = empty ? DONE : PAINT;
                    x_d     = xlo_s[CB-1:0];
                    y_d     = ylo_s[CB-1:0];
                    xlo_d   = xlo_s[CB-1:0];
                    xhi_d   = xhi_s[CB-1:0];
                    yhi_d   = yhi_s[CB-1:0];
                    col_d   = color;
                end
            end
            PAINT, CLEAR: begin
                brush_d = 1'b1;
                wx_d    = 8'(x_q);
                wy_d    = 8'(y_q);
                nc_d    = col_q;
                // Row-major walk; the x counter restarts at xlo each row.
                if (x_q == xhi_q) begin
                    x_d = xlo_q;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
                if (last) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xlo_q   <= '0;
            xhi_q   <= '0;
            yhi_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            brush_q <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            nc_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xlo_q   <= xlo_d;
            xhi_q   <= xhi_d;
            yhi_q   <= yhi_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            brush_q <= brush_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            nc_q    <= nc_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign brush    = brush_q;
    assign wx       = wx_q;
    assign wy       = wy_q;
    assign newColor = nc_q;

endmodule

// File: tb/tb_brush_painter.sv
// tb_brush_painter: directed checks of brush_painter paint, clip,
// empty footprint, clear sweep, ignored requests and mid-command reset.
module tb_brush_painter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear;
    logic [7:0] cx;
    logic [7:0] cy;
    logic [2:0] radius;
    logic [2:0] color;
    logic       busy;
    logic       done;
    logic       brush;
    logic [7:0] wx;
    logic [7:0] wy;
    logic [2:0] newColor;

    int errors = 0;
    int checks = 0;

    brush_painter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .cx       (cx),
        .cy       (cy),
        .radius   (radius),
        .color    (color),
        .busy     (busy),
        .done     (done),
        .brush    (brush),
        .wx       (wx),
        .wy       (wy),
        .newColor (newColor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write bundle as seen on the port: {brush, wx, wy, newColor}.
    function automatic logic [31:0] wr(input logic b, input int x,
                                       input int y, input int c);
        return {12'd0, b, 8'(x), 8'(y), 3'(c)};
    endfunction

    task automatic paint(input string tag, input int pcx, input int pcy,
                         input int pr, input int pcol,
                         input int xlo, input int xhi,
                         input int ylo, input int yhi,
                         input bit hold);
        int n;
        n      = 0;
        cx     = 8'(pcx);
        cy     = 8'(pcy);
        radius = 3'(pr);
        color  = 3'(pcol);
        start  = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        cx    = 8'(pcx + 77);
        cy    = 8'(pcy + 33);
        color = 3'(~pcol);
        chk({tag, "_acc_busy"}, 32'(busy), 1);
        chk({tag, "_acc_brush"}, 32'(brush), 0);
        for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                tick();
                n++;
                if (n == 2) start = 1'b0;
                chk({tag, "_wr"}, wr(brush, wx, wy, newColor),
                    wr(1'b1, x, y, pcol));
                chk({tag, "_busy"}, 32'(busy), 1);
            end
        end
        start = 1'b0;
        tick();
        chk({tag, "_done"}, {29'd0, done, brush, busy}, 32'b101);
        if (xlo <= xhi && ylo <= yhi)
            chk({tag, "_hold"}, wr(1'b0, wx, wy, newColor),
                wr(1'b0, xhi, yhi, pcol));
        tick();
        chk({tag, "_idle"}, {29'd0, done, brush, busy}, 32'b000);
        tick();
        chk({tag, "_idle2"}, {29'd0, done, brush, busy}, 32'b000);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        clear  = 1'b0;
        cx     = '0;
        cy     = '0;
        radius = '0;
        color  = '0;
        tick();
        tick();
        chk("rst_status", {29'd0, done, brush, busy}, 0);
        chk("rst_write", wr(brush, wx, wy, newColor), 0);
        reset = 1'b0;
        tick();
        chk("rst_idle", {29'd0, done, brush, busy}, 0);

        paint("interior", 40, 60, 1, 4, 39, 41, 59, 61, 1'b0);
        paint("corner_lo", 1, 0, 3, 2, 0, 4, 0, 3, 1'b0);
        paint("corner_hi", 126, 127, 2, 5, 124, 127, 125, 127, 1'b0);
        paint("edge_col", 130, 2, 3, 6, 127, 127, 0, 5, 1'b0);
        paint("empty", 200, 5, 2, 7, 1, 0, 1, 0, 1'b0);
        paint("empty_y", 5, 131, 3, 1, 1, 0, 1, 0, 1'b0);

        // Start held high through the first writes must add nothing.
        paint("ignored", 20, 30, 1, 3, 19, 21, 29, 31, 1'b1);
        paint("r0", 10, 10, 0, 6, 10, 10, 10, 10, 1'b0);

        // Clear wins over a simultaneous start.
        cx     = 8'd50;
        cy     = 8'd50;
        radius = 3'd1;
        color  = 3'd7;
        start  = 1'b1;
        clear  = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        chk("clr_acc", {29'd0, done, brush, busy}, 32'b001);
        for (int y = 0; y < 128; y++) begin
            for (int x = 0; x < 128; x++) begin
                tick();
                chk("clr_wr", wr(brush, wx, wy, newColor),
                    wr(1'b1, x, y, 0));
            end
        end
        tick();
        chk("clr_done", {29'd0, done, brush, busy}, 32'b101);
        tick();
        chk("clr_idle", {29'd0, done, brush, busy}, 32'b000);

        // Reset in the middle of a clear sweep.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        chk("mid_wr", wr(brush, wx, wy, newColor),
            wr(1'b1, 499 % 128, 499 / 128, 0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst", {29'd0, done, brush, busy}, 32'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_quiet", {29'd0, done, brush, busy}, 32'b000);
        end

        paint("after_rst", 64, 64, 1, 2, 63, 65, 63, 65, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
